lightbike_round_sequencer: RTL

Central game-flow controller for the lightbike top level. It owns the run-enable that gates the bike-update processor, and it pulses the map-clear that wipes the VGA trail memory. It sequences each round through clear, countdown, run and result, and keeps per-player scores until a match winner is reached. It consumes the per-bike crash flags from the VGA collision logic and the player-mode switch.

---
 rtl/lightbike_round_sequencer.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/lightbike_round_sequencer.sv
// Game-flow controller for the lightbike top level: sequences each round through
// clear, countdown, run and result, and tracks per-player scores up to a match win.
module lightbike_round_sequencer #(
  parameter int CLEAR_CYCLES = 4,
  parameter int TICK_CYCLES  = 10000000,
  parameter int COUNT_TICKS  = 3,
  parameter int HOLD_TICKS   = 2,
  parameter int WIN_SCORE    = 5,
  parameter int SCORE_W      = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 four_player_mode,
  input  logic [3:0]           crash,
  output logic                 run_enable,
  output logic                 map_clear,
  output logic [1:0]           countdown,
  output logic [2:0]           winner,
  output logic [4*SCORE_W-1:0] scores,
  output logic                 match_over,
  output logic [2:0]           state
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    CLEAR      = 3'd1,
    COUNTDOWN  = 3'd2,
    RUN        = 3'd3,
    RESULT     = 3'd4,
    MATCH_OVER = 3'd5
  } state_t;

  localparam int CNT_MAX = (TICK_CYCLES > CLEAR_CYCLES) ? TICK_CYCLES : CLEAR_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
  localparam int HOLD_W  = (HOLD_TICKS > 2) ? $clog2(HOLD_TICKS) : 1;

  state_t                   state_q, state_d;
  logic                     start_meta, start_sync, start_prev, start_rise;
  logic [1:0]               sync_fill;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [HOLD_W-1:0]        hold_q, hold_d;
  logic [1:0]               countdown_d;
  logic [2:0]               winner_d;
  logic [3:0][SCORE_W-1:0]  score_q, score_d;
  logic [3:0]               alive_q;
  logic                     mode4, restart_q, restart_d;
  logic                     tick, any_win;

  // Held start after reset must not look like a rising edge, so the edge
  // detector only follows start_sync once the synchroniser holds real samples.
  assign start_rise = start_sync & ~start_prev;
  assign tick       = (cnt_q == CNT_W'(TICK_CYCLES - 1));
  assign scores     = score_q;
  assign state      = state_q;

  always_comb begin
    any_win = 1'b0;
    for (int i = 0; i < 4; i++)
      if (score_q[i] == SCORE_W'(WIN_SCORE)) any_win = 1'b1;
  end

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d     = state_q;
    countdown_d = countdown;
    winner_d    = winner;
    score_d     = score_q;
    hold_d      = hold_q;
    restart_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start_rise || restart_q) begin
          state_d  = CLEAR;
          score_d  = '0;
          winner_d = 3'd0;
        end
      end
      CLEAR: begin
        if (cnt_q == CNT_W'(CLEAR_CYCLES - 1)) begin
          state_d     = COUNTDOWN;
          countdown_d = 2'(COUNT_TICKS);
        end
      end
      COUNTDOWN: begin
        if (tick) begin
          if (countdown == 2'd1) begin
            state_d     = RUN;
            countdown_d = 2'd0;
          end else begin
            countdown_d = countdown - 2'd1;
          end
        end
      end
      RUN: begin
        // A paused game keeps sampling crashes but never resolves the round.
        if (start_sync && ($countones(alive_q) <= 1)) begin
          state_d  = RESULT;
          hold_d   = '0;
          winner_d = 3'd0;
          for (int i = 0; i < 4; i++) begin
            if (alive_q[i]) begin
              winner_d = 3'(i + 1);
              if (score_q[i] < SCORE_W'(WIN_SCORE)) score_d[i] = score_q[i] + 1'b1;
            end
          end
        end
      end
      RESULT: begin
        if (tick) begin
          if (hold_q == HOLD_W'(HOLD_TICKS - 1)) begin
            hold_d  = '0;
            state_d = any_win ? MATCH_OVER : CLEAR;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
      end
      MATCH_OVER: begin
        if (start_rise) begin
          state_d   = IDLE;
          restart_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // CLEAR counts single cycles without wrapping; other states count ticks.
    if ((state_d != state_q) || ((state_q != CLEAR) && tick)) cnt_d = '0;
    else                                                    cnt_d = cnt_q + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      start_meta <= 1'b0;
      start_sync <= 1'b0;
      start_prev <= 1'b1;
      sync_fill  <= 2'b00;
      state_q    <= IDLE;
      cnt_q      <= '0;
      hold_q     <= '0;
      score_q    <= '0;
      alive_q    <= '0;
      mode4      <= 1'b0;
      restart_q  <= 1'b0;
      run_enable <= 1'b0;
      map_clear  <= 1'b0;
      countdown  <= 2'd0;
      winner     <= 3'd0;
      match_over <= 1'b0;
    end else begin
      start_meta <= start;
      start_sync <= start_meta;
      sync_fill  <= {sync_fill[0], 1'b1};
      start_prev <= sync_fill[1] ? start_sync : 1'b1;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hold_q     <= hold_d;
      score_q    <= score_d;
      alive_q    <= ~crash & (mode4 ? 4'b1111 : 4'b0011);
      if (state_q == CLEAR) mode4 <= four_player_mode;
      restart_q  <= restart_d;
      run_enable <= (state_d == RUN) && start_sync;
      map_clear  <= (state_d == CLEAR);
      countdown  <= countdown_d;
      winner     <= winner_d;
      match_over <= (state_d == MATCH_OVER);
    end
  end

endmodule
